// File: rtl/fir_sample_queue.sv
// Multi-channel circular sample queue for the FIR filter bank.
// Each accepted sample is written to per-channel RAM. Once TAPS samples are
// held, an accepted write in IDLE starts a burst that reads back the newest
// TAPS samples, oldest first, one per clock.

// One channel: simple dual-port RAM with a registered, clearable read port.
module fir_sample_queue_lane #(
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // RAM write port; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; holds its value between bursts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i)  rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module fir_sample_queue #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int TAPS       = 1021,
  parameter int NUM_CH     = 2,
  parameter int DECIM      = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clr_i,
  input  logic                       wrt_smpl_i,
  input  logic [NUM_CH*DATA_W-1:0]   smpl_in_i,
  output logic [NUM_CH*DATA_W-1:0]   smpl_out_o,
  output logic                       smpl_vld_o,
  output logic                       sequencing_o,
  output logic                       seq_done_o,
  output logic                       full_o,
  output logic [$clog2(TAPS+1)-1:0]  fill_cnt_o,
  output logic                       overrun_o
);
  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int FW    = $clog2(TAPS+1);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  // wr_ptr + OFS == oldest of the newest TAPS samples, counting the one being written
  localparam int OFS   = (DEPTH + 1 - TAPS) % DEPTH;

  typedef enum logic [1:0] {IDLE, READ, LAST} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d, fill_inc, rcnt_q, rcnt_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic              vld_q, done_q, ovr_q;
  logic              accept, trigger, rd_en, last_rd;

  assign accept   = wrt_smpl_i && (dec_q == '0);
  assign fill_inc = (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);
  assign trigger  = accept && (state_q == IDLE) && (fill_inc == FW'(TAPS));
  assign rd_en    = (state_q == READ);
  assign last_rd  = rd_en && (rcnt_q == FW'(TAPS-1));

  // Next-state: pointers, fill count, decimation counter and burst FSM.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    rcnt_d   = rcnt_q;
    dec_d    = dec_q;
    if (wrt_smpl_i) dec_d = (dec_q == DEC_W'(DECIM-1)) ? '0 : dec_q + DEC_W'(1);
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      fill_d   = fill_inc;
    end
    case (state_q)
      IDLE: if (trigger) begin
        state_d  = READ;
        rd_ptr_d = wr_ptr_q + AW'(OFS);
        rcnt_d   = '0;
      end
      READ: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rcnt_d   = rcnt_q + FW'(1);
        if (last_rd) state_d = LAST;
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; clr wipes everything but RAM contents.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE; wr_ptr_q <= '0; rd_ptr_q <= '0; fill_q <= '0;
      rcnt_q <= '0; dec_q <= '0; vld_q <= 1'b0; done_q <= 1'b0; ovr_q <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE; wr_ptr_q <= '0; rd_ptr_q <= '0; fill_q <= '0;
      rcnt_q <= '0; dec_q <= '0; vld_q <= 1'b0; done_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      rcnt_q   <= rcnt_d;
      dec_q    <= dec_d;
      vld_q    <= rd_en;
      done_q   <= last_rd;
      ovr_q    <= ovr_q | (accept && (state_q != IDLE));
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fir_sample_queue_lane #(.DATA_W(DATA_W), .AW(AW)) u_lane (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_i),
      .we_i    (accept && !clr_i),
      .waddr_i (wr_ptr_q),
      .wdata_i (smpl_in_i[c*DATA_W +: DATA_W]),
      .re_i    (rd_en && !clr_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (smpl_out_o[c*DATA_W +: DATA_W])
    );
  end

  assign smpl_vld_o   = vld_q;
  assign seq_done_o   = done_q;
  assign sequencing_o = (state_q != IDLE);
  assign full_o       = (fill_q == FW'(TAPS));
  assign fill_cnt_o   = fill_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_fir_sample_queue.sv
// Directed bench for fir_sample_queue: fill, steady/wrap, timing, overrun,
// clr/reset abort, and decimation on a second instance.
module tb_fir_sample_queue;
  localparam int TAPS = 5;

  logic        clk = 0, rst_n = 0, clr = 0, wrt = 0, wrt2 = 0;
  logic [31:0] din = '0, din2 = '0;
  logic [31:0] dout, dout2;
  logic        vld, seqg, done, full, ovr, vld2, seqg2, done2, full2, ovr2;
  logic [2:0]  fill, fill2;
  int          checks = 0, errors = 0;
  logic [15:0] hist[$];
  logic [15:0] got2[$];

  fir_sample_queue #(.DATA_W(16), .DEPTH_LOG2(3), .TAPS(TAPS), .NUM_CH(2), .DECIM(1)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wrt_smpl_i(wrt), .smpl_in_i(din),
    .smpl_out_o(dout), .smpl_vld_o(vld), .sequencing_o(seqg), .seq_done_o(done),
    .full_o(full), .fill_cnt_o(fill), .overrun_o(ovr));

  fir_sample_queue #(.DATA_W(16), .DEPTH_LOG2(3), .TAPS(TAPS), .NUM_CH(2), .DECIM(2)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(1'b0), .wrt_smpl_i(wrt2), .smpl_in_i(din2),
    .smpl_out_o(dout2), .smpl_vld_o(vld2), .sequencing_o(seqg2), .seq_done_o(done2),
    .full_o(full2), .fill_cnt_o(fill2), .overrun_o(ovr2));

  always #5 clk = ~clk;

  always @(negedge clk) if (vld2) got2.push_back(dout2[15:0]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int v);
    return {v[15:0] + 16'h0100, v[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accepted-write pulse; returns in cycle E+1.
  task automatic wr(input int v);
    wrt = 1; din = pk(v); hist.push_back(v[15:0]);
    tick();
    wrt = 0;
  endtask

  // Check a full burst started by the write just issued; optionally inject an
  // overrun write during it (ovr_v >= 0).
  task automatic burst(input int ovr_v);
    logic [15:0] e[TAPS];
    int base = hist.size() - TAPS;
    for (int i = 0; i < TAPS; i++) e[i] = hist[base + i];
    chk("seq_e1", 32'(seqg), 1);
    chk("vld_e1", 32'(vld), 0);
    for (int k = 0; k < TAPS; k++) begin
      tick();
      wrt = 0;
      chk("vld_burst", 32'(vld), 1);
      chk("seq_burst", 32'(seqg), 1);
      chk("dout_burst", dout, pk(e[k]));
      chk("done_burst", 32'(done), 32'(k == TAPS-1));
      if (k == 0 && ovr_v >= 0) begin
        wrt = 1; din = pk(ovr_v); hist.push_back(ovr_v[15:0]);
      end
    end
    tick();
    chk("seq_idle", 32'(seqg), 0);
    chk("vld_idle", 32'(vld), 0);
    chk("done_idle", 32'(done), 0);
  endtask

  task automatic refill(input int v0);
    hist.delete();
    for (int v = v0; v < v0 + 4; v++) begin
      wr(v);
      chk("refill_seq", 32'(seqg), 0);
      chk("refill_cnt", 32'(fill), 32'(v - v0 + 1));
      tick();
      chk("refill_vld", 32'(vld), 0);
    end
    wr(v0 + 4);
    chk("refill_full", 32'(full), 1);
    burst(-1);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_vld", 32'(vld), 0);
    chk("rst_seq", 32'(seqg), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_dout", dout, 0);
    rst_n = 1;
    tick();

    // Fill 1..4, fifth write triggers first burst
    for (int v = 1; v <= 4; v++) begin
      wr(v);
      chk("fill_cnt", 32'(fill), 32'(v));
      chk("fill_full", 32'(full), 0);
      chk("fill_seq", 32'(seqg), 0);
      repeat (3) tick();
      chk("fill_vld", 32'(vld), 0);
    end
    wr(5);
    chk("full_5", 32'(full), 1);
    chk("fill_5", 32'(fill), 5);
    burst(-1);

    // Steady state with pointer wrap
    for (int v = 6; v <= 12; v++) begin
      repeat (3) tick();
      wr(v);
      burst(-1);
    end

    // Overrun: second write mid-burst
    repeat (3) tick();
    wr(13);
    burst(14);
    chk("ovr_set", 32'(ovr), 1);
    for (int i = 0; i < 5; i++) begin
      chk("ovr_noburst", 32'(seqg), 0);
      tick();
    end
    chk("ovr_fill", 32'(fill), 5);
    wr(15);
    burst(-1);

    // clr mid-burst
    repeat (3) tick();
    wr(16);
    tick();
    clr = 1;
    tick();
    clr = 0;
    chk("clr_vld", 32'(vld), 0);
    chk("clr_seq", 32'(seqg), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_fill", 32'(fill), 0);
    chk("clr_full", 32'(full), 0);
    chk("clr_ovr", 32'(ovr), 0);
    chk("clr_dout", dout, 0);
    refill(20);

    // async reset mid-burst
    repeat (3) tick();
    wr(25);
    tick(); tick();
    rst_n = 0;
    #1;
    chk("arst_vld", 32'(vld), 0);
    chk("arst_seq", 32'(seqg), 0);
    chk("arst_fill", 32'(fill), 0);
    chk("arst_dout", dout, 0);
    tick();
    rst_n = 1;
    tick();
    refill(30);

    // Decimation by 2 on the second instance
    got2.delete();
    for (int v = 1; v <= 10; v++) begin
      wrt2 = 1; din2 = pk(v);
      tick();
      wrt2 = 0;
      if (v == 2) chk("dec_fill2", 32'(fill2), 1);
      if (v == 9) chk("dec_seq9", 32'(seqg2), 1);
      repeat (9) tick();
    end
    chk("dec_cnt", 32'(got2.size()), 5);
    for (int i = 0; i < 5; i++)
      chk("dec_data", (i < got2.size()) ? 32'(got2[i]) : 32'hdead, 32'(2*i + 1));
    chk("dec_fill", 32'(fill2), 5);
    chk("dec_ovr", 32'(ovr2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
